// File: rtl/brush_pkg.sv
// Shared encodings for the bathroom heater controller: power-sequence states
// and the fixed function channel indices.
package brush_pkg;
    localparam int STATE_W   = 2;
    localparam int FUNC_HEAT = 0;
    localparam int FUNC_FAN  = 1;

    typedef enum logic [STATE_W-1:0] {
        OFF      = 2'd0,
        STARTUP  = 2'd1,
        RUN      = 2'd2,
        COOLDOWN = 2'd3
    } state_t;
endpackage

// File: rtl/sec_tick.sv
// Free-running prescaler producing a one-cycle tick every CLK_DIV cycles.
module sec_tick #(
    parameter int CLK_DIV = 1000000
) (
    input  logic clk1M,
    input  logic rst,
    output logic tick
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic          tick_q;

    always_ff @(posedge clk1M) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (cnt_q == CW'(CLK_DIV - 1)) begin
            cnt_q  <= '0;
            tick_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_q + CW'(1);
            tick_q <= 1'b0;
        end
    end

    assign tick = tick_q;
endmodule

// File: rtl/heater_mode_ctrl.sv
// Heater mode controller: power sequencing, heat/fan interlock, function
// toggles and auto-off countdown, all driven from the shared 1 s tick.
module heater_mode_ctrl
    import brush_pkg::*;
#(
    parameter int NUM_FUNC     = 4,
    parameter int CLK_DIV      = 1000000,
    parameter int STARTUP_S    = 3,
    parameter int RUNON_S      = 30,
    parameter int TIMER_STEP_S = 600,
    parameter int TIMER_STEPS  = 6,
    localparam int TW          = $clog2(TIMER_STEP_S * TIMER_STEPS + 1)
) (
    input  logic                clk1M,
    input  logic                rst,
    input  logic                key_power,
    input  logic [NUM_FUNC-1:0] key_func,
    input  logic                key_timer,
    output logic [NUM_FUNC-1:0] func_on,
    output logic [STATE_W-1:0]  state,
    output logic                busy,
    output logic [TW-1:0]       timer_left,
    output logic                tick
);
    localparam int PMAX = (STARTUP_S > RUNON_S) ? STARTUP_S : RUNON_S;
    localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
    localparam int SW   = $clog2(TIMER_STEPS + 1);

    state_t              state_q;
    logic [NUM_FUNC-1:0] func_q;
    logic [TW-1:0]       timer_q;
    logic [SW-1:0]       step_q;
    logic [PW-1:0]       phase_q;
    logic                runon_q;
    logic                tick_w;

    logic [NUM_FUNC-1:0] func_tog_d;
    logic [NUM_FUNC-1:0] func_cd_d;
    logic                expire_w;

    sec_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk1M (clk1M),
        .rst   (rst),
        .tick  (tick_w)
    );

    // Toggle every pressed channel first, then let heat pull the fan on.
    always_comb begin
        func_tog_d = func_q ^ key_func;
        if (func_tog_d[FUNC_HEAT]) func_tog_d[FUNC_FAN] = 1'b1;
        func_cd_d = '0;
        func_cd_d[FUNC_FAN] = func_q[FUNC_FAN];
    end

    // A timer key in the same cycle reloads the setting, so it masks expiry.
    assign expire_w = tick_w && (timer_q == TW'(1)) && !key_timer;

    always_ff @(posedge clk1M) begin
        if (rst) begin
            state_q <= OFF;
            func_q  <= '0;
            timer_q <= '0;
            step_q  <= '0;
            phase_q <= '0;
            runon_q <= 1'b0;
        end else begin
            case (state_q)
                OFF: begin
                    if (key_power) begin
                        state_q <= STARTUP;
                        phase_q <= '0;
                    end
                end
                STARTUP: begin
                    if (tick_w) begin
                        if (phase_q == PW'(STARTUP_S - 1)) begin
                            state_q <= RUN;
                            phase_q <= '0;
                        end else begin
                            phase_q <= phase_q + PW'(1);
                        end
                    end
                end
                RUN: begin
                    if (key_power || expire_w) begin
                        state_q <= COOLDOWN;
                        runon_q <= func_q[FUNC_HEAT];
                        func_q  <= func_cd_d;
                        timer_q <= '0;
                        step_q  <= '0;
                        phase_q <= '0;
                    end else begin
                        func_q <= func_tog_d;
                        if (key_timer) begin
                            if (step_q == SW'(TIMER_STEPS)) begin
                                step_q  <= '0;
                                timer_q <= '0;
                            end else begin
                                step_q  <= step_q + SW'(1);
                                timer_q <= TW'((int'(step_q) + 1) * TIMER_STEP_S);
                            end
                        end else if (tick_w && timer_q != '0) begin
                            timer_q <= timer_q - TW'(1);
                        end
                    end
                end
                COOLDOWN: begin
                    if (!runon_q) begin
                        state_q <= OFF;
                        func_q  <= '0;
                    end else if (tick_w) begin
                        if (phase_q == PW'(RUNON_S - 1)) begin
                            state_q <= OFF;
                            func_q  <= '0;
                            runon_q <= 1'b0;
                            phase_q <= '0;
                        end else begin
                            phase_q <= phase_q + PW'(1);
                        end
                    end
                end
                default: state_q <= OFF;
            endcase
        end
    end

    assign func_on    = func_q;
    assign state      = state_q;
    assign busy       = (state_q == STARTUP) || (state_q == COOLDOWN);
    assign timer_left = timer_q;
    assign tick       = tick_w;
endmodule

// File: tb/tb_heater_mode_ctrl.sv
// Directed bench for heater_mode_ctrl with a per-cycle reference model.
module tb_heater_mode_ctrl;
    localparam int NF  = 4;
    localparam int CD  = 10;
    localparam int SS  = 2;
    localparam int RS  = 3;
    localparam int TSS = 5;
    localparam int TST = 2;
    localparam int TW  = $clog2(TSS * TST + 1);

    logic          clk1M = 1'b0;
    logic          rst = 1'b1;
    logic          key_power = 1'b0;
    logic [NF-1:0] key_func = '0;
    logic          key_timer = 1'b0;
    logic [NF-1:0] func_on;
    logic [1:0]    state;
    logic          busy;
    logic [TW-1:0] timer_left;
    logic          tick;

    int checks = 0;
    int errors = 0;

    heater_mode_ctrl #(
        .NUM_FUNC(NF), .CLK_DIV(CD), .STARTUP_S(SS), .RUNON_S(RS),
        .TIMER_STEP_S(TSS), .TIMER_STEPS(TST)
    ) dut (
        .clk1M(clk1M), .rst(rst), .key_power(key_power), .key_func(key_func),
        .key_timer(key_timer), .func_on(func_on), .state(state), .busy(busy),
        .timer_left(timer_left), .tick(tick)
    );

    always #5 clk1M = ~clk1M;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Reference model: seconds-level behaviour with a plain edge counter.
    int          m_st, m_tmr, m_set, m_left, m_n;
    logic [NF-1:0] m_func;
    bit          m_hold, m_tick, m_ok = 0;

    always @(posedge clk1M) begin : model
        bit t;
        if (rst) begin
            m_st = 0; m_func = '0; m_tmr = 0; m_set = 0; m_left = 0;
            m_hold = 0; m_n = 0; m_tick = 0; m_ok = 1;
        end else begin
            t = m_tick;
            case (m_st)
                0: if (key_power) begin m_st = 1; m_left = SS; end
                1: if (t) begin m_left--; if (m_left == 0) m_st = 2; end
                2: begin
                    if (key_power || (t && m_tmr == 1 && !key_timer)) begin
                        m_hold = m_func[0];
                        m_func = m_func & 4'b0010;
                        m_tmr = 0; m_set = 0; m_st = 3; m_left = RS;
                    end else begin
                        for (int i = 0; i < NF; i++)
                            if (key_func[i]) m_func[i] = ~m_func[i];
                        if (m_func[0]) m_func[1] = 1'b1;
                        if (key_timer) begin
                            m_set = (m_set + 1) % (TST + 1);
                            m_tmr = m_set * TSS;
                        end else if (t && m_tmr > 0) begin
                            m_tmr--;
                        end
                    end
                end
                default: begin
                    if (!m_hold) begin
                        m_st = 0; m_func = '0;
                    end else if (t) begin
                        m_left--;
                        if (m_left == 0) begin m_st = 0; m_func = '0; m_hold = 0; end
                    end
                end
            endcase
            m_n++;
            m_tick = (m_n % CD) == 0;
        end
    end

    always @(negedge clk1M) begin
        if (m_ok) begin
            chk("state", int'(state), m_st);
            chk("func_on", int'(func_on), int'(m_func));
            chk("timer_left", int'(timer_left), m_tmr);
            chk("busy", int'(busy), int'(m_st == 1 || m_st == 3));
            chk("tick", int'(tick), int'(m_tick));
        end
    end

    task automatic pulse(input bit p, input logic [NF-1:0] f, input bit t);
        key_power = p; key_func = f; key_timer = t;
        @(negedge clk1M);
        key_power = 0; key_func = '0; key_timer = 0;
    endtask

    task automatic wait_state(input int s, input int bound, output int n);
        n = 0;
        while (int'(state) != s && n < bound) begin
            @(negedge clk1M);
            n++;
        end
        if (int'(state) != s) chk("wait_state_timeout", int'(state), s);
    endtask

    task automatic power_up();
        int n;
        pulse(1, '0, 0);
        chk("pwr_startup", int'(state), 1);
        wait_state(2, 30, n);
        chk_rng("startup_len", n, 11, 20);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk1M);
        chk("rst_state", int'(state), 0);
        chk("rst_func", int'(func_on), 0);
        chk("rst_timer", int'(timer_left), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tick", int'(tick), 0);
        rst = 0;
        repeat (4) @(negedge clk1M);

        power_up();
        chk("run_func_zero", int'(func_on), 0);

        pulse(0, 4'b0001, 0); chk("il_heat", int'(func_on), 4'b0011);
        pulse(0, 4'b0010, 0); chk("il_fan_ign", int'(func_on), 4'b0011);
        pulse(0, 4'b0001, 0); chk("il_heat_off", int'(func_on), 4'b0010);
        pulse(0, 4'b0010, 0); chk("il_fan_off", int'(func_on), 4'b0000);

        pulse(0, '0, 1); chk("tmr_5", int'(timer_left), 5);
        @(negedge clk1M);
        pulse(0, '0, 1); chk("tmr_10", int'(timer_left), 10);
        @(negedge clk1M);
        pulse(0, '0, 1); chk("tmr_wrap", int'(timer_left), 0);
        pulse(0, '0, 1); chk("tmr_5b", int'(timer_left), 5);
        wait_state(3, 70, n);
        chk_rng("expiry_len", n, 41, 50);
        @(negedge clk1M);
        chk("expiry_off", int'(state), 0);

        power_up();
        pulse(0, 4'b0001, 0); chk("ro_heat", int'(func_on), 4'b0011);
        pulse(1, '0, 0);
        chk("ro_func", int'(func_on), 4'b0010);
        chk("ro_state", int'(state), 3);
        wait_state(0, 40, n);
        chk_rng("runon_len", n, 21, 30);
        chk("ro_done_func", int'(func_on), 0);

        power_up();
        pulse(0, 4'b1000, 0); chk("sim_pre", int'(func_on), 4'b1000);
        pulse(1, 4'b0100, 0);
        chk("sim_state", int'(state), 3);
        chk("sim_func", int'(func_on), 0);
        @(negedge clk1M);
        chk("sim_off", int'(state), 0);
        repeat (5) @(negedge clk1M);
        chk("sim_once", int'(state), 0);

        power_up();
        pulse(0, 4'b0001, 0);
        pulse(1, '0, 0);
        repeat (8) @(negedge clk1M);
        chk("mid_cd_state", int'(state), 3);
        chk("mid_cd_func", int'(func_on), 4'b0010);
        rst = 1;
        @(negedge clk1M);
        rst = 0;
        chk("mrst_state", int'(state), 0);
        chk("mrst_func", int'(func_on), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_tick", int'(tick), 0);
        pulse(0, 4'b0001, 1);
        chk("mrst_ign_state", int'(state), 0);
        chk("mrst_ign_func", int'(func_on), 0);
        chk("mrst_ign_timer", int'(timer_left), 0);
        pulse(1, '0, 0);
        chk("mrst_repower", int'(state), 1);
        repeat (3) @(negedge clk1M);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end
endmodule
